button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 The block SHALL have parameter N_BTN, default 5, giving the number of independent button channels (c, u, l, r, d order, bit 0 = btnc).
REQ-002 The block SHALL have parameter STABLE_CYCLES, default 1_000_000 (10 ms at 100 MHz), giving the number of consecutive stable cycles required to accept a new level; legal range 2..2^20-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port btn_raw, input, N_BTN bits: raw asynchronous push-button levels, 1 = pressed.
REQ-006 The block SHALL have port btn_level, output, N_BTN bits: debounced button level, registered.
REQ-007 The block SHALL have port btn_press, output, N_BTN bits: one-cycle pulse on an accepted 0->1 transition, registered.
REQ-008 The block SHALL have port btn_release, output, N_BTN bits: one-cycle pulse on an accepted 1->0 transition, registered.

Function
REQ-009 Each channel SHALL pass btn_raw through a two-flop synchronizer; the second flop output is sync_q.
REQ-010 Each channel SHALL hold a counter of width CNT_W = clog2(STABLE_CYCLES).
REQ-011 When sync_q equals btn_level for that channel, the counter SHALL clear to 0 on the next edge.
REQ-012 When sync_q differs from btn_level and the counter is below STABLE_CYCLES-1, the counter SHALL increment by 1.
REQ-013 When sync_q differs from btn_level and the counter equals STABLE_CYCLES-1, on the next edge btn_level SHALL take sync_q, the counter SHALL clear to 0, and btn_press or btn_release SHALL assert for exactly that one cycle.
REQ-014 Latency from the first clock edge sampling a new stable raw level to the btn_level update SHALL be exactly 2 + STABLE_CYCLES edges.
REQ-015 A single-cycle return of sync_q to the current btn_level (glitch) SHALL restart the count from 0; shorter-than-threshold bounces SHALL produce no output change and no pulse.
REQ-016 The counter SHALL never wrap; it saturates by design at STABLE_CYCLES-1 because REQ-013 clears it.
REQ-017 btn_press and btn_release of one channel SHALL never be asserted in the same cycle; pulses SHALL be deasserted in every cycle without an accepted transition.
REQ-018 Channels SHALL be fully independent; simultaneous transitions on several channels SHALL each produce their own pulse in the same cycle.
REQ-019 A raw level held steadily for longer than the threshold SHALL produce exactly one pulse, with no repeat.

Reset
REQ-020 While rst_n = 0, synchronizer flops, counters, btn_level, btn_press and btn_release SHALL all be 0, asynchronously.
REQ-021 Reset asserted mid-count SHALL discard the count; after release, a button already held SHALL be accepted as a fresh press after 2 + STABLE_CYCLES edges.
REQ-022 Deassertion of rst_n SHALL be synchronized externally; the block does not re-synchronize it.

Structure
REQ-023 A shared package (board_pkg) SHALL hold CLK_HZ = 100_000_000, DEBOUNCE_MS = 10, the derived default STABLE_CYCLES, and the N_BTN default.
REQ-024 Per-channel logic SHALL live in one sub-module, debounce_channel, instantiated N_BTN times by a generate loop.
REQ-025 The sub-module SHALL contain the synchronizer, counter, level register and pulse registers; the top-level module contains only instantiation and bus wiring.

Verification (STABLE_CYCLES = 4)
REQ-026 Reset with btn_raw = 5'b11111, release at edge 0 -> all outputs 0 until edge 6; btn_level = 5'b11111 and btn_press = 5'b11111 for one cycle at edge 6.
REQ-027 btn_raw[0] 0->1 held -> btn_level[0] rises exactly 6 edges later; btn_press[0] asserts one cycle; no btn_release.
REQ-028 btn_raw[2] toggles 1-on/1-off for 20 cycles, then held at 0 from a 0 level -> no pulse and btn_level[2] stays 0 throughout.
REQ-029 btn_raw[3] high for 3 cycles, low 1 cycle, then high held -> btn_level[3] rises 6 edges after the final rising edge sample, single press pulse.
REQ-030 rst_n asserted 2 cycles into a 4-cycle count on btn[1] -> outputs clear immediately; after release, btn[1] still held -> press at edge 6 after release.
REQ-031 Press accepted, then btn_raw[4] 1->0 held -> btn_release[4] one cycle at 6 edges; btn_press[4] stays 0.

Source files
------------

// File: rtl/board_pkg.sv
// Board-level constants shared by the push-button front end.
// The default debounce threshold comes from the board clock and the
// wanted settling window, so changing either one updates it everywhere.
package board_pkg;

    // System clock frequency of the board in Hz.
    localparam int CLK_HZ = 100_000_000;

    // Time a button must hold a new level before it is believed, in ms.
    localparam int DEBOUNCE_MS = 10;

    // Number of push buttons on the board: centre, up, left, right, down.
    localparam int N_BTN_DEFAULT = 5;

    // Bit position of each button on the button buses (bit 0 = centre).
    typedef enum logic [2:0] {
        BTN_C = 3'd0,
        BTN_U = 3'd1,
        BTN_L = 3'd2,
        BTN_R = 3'd3,
        BTN_D = 3'd4
    } btn_idx_e;

    // Converts a settling window in milliseconds into clock cycles.
    function automatic int debounceCycles(input int clkHz, input int ms);
        return (clkHz / 1000) * ms;
    endfunction

    // 10 ms at 100 MHz = 1_000_000 consecutive stable cycles.
    localparam int STABLE_CYCLES_DEFAULT = debounceCycles(CLK_HZ, DEBOUNCE_MS);

endpackage

// File: rtl/debounce_channel.sv
// One debounced push-button channel: a two-flop synchronizer, a
// stability counter, the accepted level register and the press/release
// pulse registers. A new level is accepted only after the synchronized
// input has disagreed with the current level for STABLE_CYCLES
// consecutive cycles; any single cycle of agreement restarts the count.
module debounce_channel
    import board_pkg::*;
#(
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    // The counter only ever reaches STABLE_CYCLES-1, so clog2 bits suffice.
    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             r_syncMeta;
    logic             r_syncQ;
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;

    logic             w_differs;
    logic             w_accept;

    // The synchronized input disagrees with the level we currently report.
    assign w_differs = r_syncQ ^ r_level;

    // Final disagreeing cycle of a full stable run: take the new level now.
    assign w_accept  = w_differs && (r_cnt == CNT_LAST);

    // Two-flop synchronizer bringing the asynchronous button into clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_syncMeta <= 1'b0;
            r_syncQ    <= 1'b0;
        end else begin
            r_syncMeta <= i_raw;
            r_syncQ    <= r_syncMeta;
        end
    end

    // Stability counter: clears on agreement or acceptance, so it never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!w_differs || w_accept) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Accepted level plus one-cycle press/release pulses on each acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            if (w_accept) begin
                r_level <= r_syncQ;
            end
            r_press   <= w_accept &  r_syncQ;
            r_release <= w_accept & ~r_syncQ;
        end
    end

    assign o_level   = r_level;
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/button_debouncer.sv
// Debouncer for the board push buttons. Each bit of the bus is an
// independent channel; this level only replicates debounce_channel and
// wires the per-channel outputs back onto the buses.
module button_debouncer
    import board_pkg::*;
#(
    parameter int N_BTN         = N_BTN_DEFAULT,
    parameter int STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release
);

    // One channel per button bit, all sharing clock, reset and threshold.
    for (genvar g = 0; g < N_BTN; g++) begin : gen_chan
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_raw    (btn_raw[g]),
            .o_level  (btn_level[g]),
            .o_press  (btn_press[g]),
            .o_release(btn_release[g])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Self-checking bench for button_debouncer with a short threshold.
// Each driven cycle pushes the expected outputs onto a scoreboard,
// and they are popped and compared once the edge has happened.
module tb_button_debouncer;

    localparam int N  = 5;
    localparam int SC = 4;

    typedef struct packed {
        logic [N-1:0] level;
        logic [N-1:0] press;
        logic [N-1:0] rel;
    } expect_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] btn_raw;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;

    expect_t      sbQ[$];
    int           vectorCount = 0;
    int           missCount   = 0;
    int           edgeNo      = 0;
    int           agreeEdge[N];
    logic [N-1:0] mS1  = '0;
    logic [N-1:0] mS2  = '0;
    logic [N-1:0] mLvl = '0;
    logic [N-1:0] cur;
    logic         seen;

    button_debouncer #(
        .N_BTN(N),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    // Counts one comparison and reports it when it does not hold.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectorCount++;
        if (obs !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %h, expected %h (edge %0d)", tag, obs, exp, edgeNo);
        end
    endtask

    // Drives one cycle of raw input, predicts the outputs after the next
    // rising edge, then compares them on the following falling edge.
    // The model accepts a level once the synchronized input has disagreed
    // with it for SC edges since the last edge where they agreed.
    task automatic applyStimulus(input logic [N-1:0] raw);
        expect_t e;
        btn_raw = raw;
        edgeNo++;
        e = '0;
        if (!rst_n) begin
            mS1  = '0;
            mS2  = '0;
            mLvl = '0;
            for (int i = 0; i < N; i++) agreeEdge[i] = edgeNo;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (mS2[i] == mLvl[i]) begin
                    agreeEdge[i] = edgeNo;
                end else if (edgeNo - agreeEdge[i] >= SC) begin
                    mLvl[i]      = mS2[i];
                    agreeEdge[i] = edgeNo;
                    if (mS2[i]) e.press[i] = 1'b1;
                    else        e.rel[i]   = 1'b1;
                end
            end
            mS2 = mS1;
            mS1 = raw;
        end
        e.level = mLvl;
        sbQ.push_back(e);
        @(posedge clk);
        @(negedge clk);
        e = sbQ.pop_front();
        checkOutput("sb_level",   32'(btn_level),   32'(e.level));
        checkOutput("sb_press",   32'(btn_press),   32'(e.press));
        checkOutput("sb_release", 32'(btn_release), 32'(e.rel));
    endtask

    initial begin
        rst_n   = 1'b0;
        cur     = '1;
        btn_raw = cur;
        #1;
        checkOutput("rst_level",   32'(btn_level),   32'h0);
        checkOutput("rst_press",   32'(btn_press),   32'h0);
        checkOutput("rst_release", 32'(btn_release), 32'h0);
        repeat (3) applyStimulus(cur);

        // All buttons held through reset: fresh press of all at edge 6.
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(cur);
            if (c == 5) checkOutput("all_level_e5", 32'(btn_level), 32'h00);
            if (c == 6) begin
                checkOutput("all_level_e6", 32'(btn_level), 32'h1f);
                checkOutput("all_press_e6", 32'(btn_press), 32'h1f);
            end
            if (c == 7) checkOutput("all_press_e7", 32'(btn_press), 32'h00);
        end

        cur = '0;
        repeat (8) applyStimulus(cur);

        // Centre button press held.
        cur[0] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(cur);
            if (c == 5) checkOutput("c_level_e5", 32'(btn_level[0]), 32'h0);
            if (c == 6) begin
                checkOutput("c_level_e6", 32'(btn_level[0]), 32'h1);
                checkOutput("c_press_e6", 32'(btn_press[0]), 32'h1);
            end
            if (c == 7) checkOutput("c_press_e7", 32'(btn_press[0]), 32'h0);
        end

        // Left button bouncing every cycle, then settling low.
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cur[2] = (k % 2 == 0);
            applyStimulus(cur);
            seen = seen | btn_level[2] | btn_press[2] | btn_release[2];
        end
        cur[2] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(cur);
            seen = seen | btn_level[2] | btn_press[2] | btn_release[2];
        end
        checkOutput("l_bounce_quiet", 32'(seen), 32'h0);

        // Right button: short high, one-cycle dropout, then held high.
        cur[3] = 1'b1;
        repeat (3) applyStimulus(cur);
        cur[3] = 1'b0;
        applyStimulus(cur);
        cur[3] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            applyStimulus(cur);
            if (c == 5) checkOutput("r_level_e5", 32'(btn_level[3]), 32'h0);
            if (c == 6) begin
                checkOutput("r_level_e6", 32'(btn_level[3]), 32'h1);
                checkOutput("r_press_e6", 32'(btn_press[3]), 32'h1);
            end
        end

        // Up button: reset lands two cycles into its count.
        cur[1] = 1'b1;
        repeat (4) applyStimulus(cur);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("async_level",   32'(btn_level),   32'h0);
        checkOutput("async_press",   32'(btn_press),   32'h0);
        checkOutput("async_release", 32'(btn_release), 32'h0);
        repeat (2) applyStimulus(cur);
        rst_n = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(cur);
            if (c == 5) checkOutput("u_level_e5", 32'(btn_level[1]), 32'h0);
            if (c == 6) begin
                checkOutput("u_level_e6", 32'(btn_level), 32'h0b);
                checkOutput("u_press_e6", 32'(btn_press), 32'h0b);
            end
        end

        // Down button: accepted press, then release held.
        cur[4] = 1'b1;
        repeat (8) applyStimulus(cur);
        checkOutput("d_level_on", 32'(btn_level[4]), 32'h1);
        cur[4] = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            applyStimulus(cur);
            seen = seen | btn_press[4];
            if (c == 5) checkOutput("d_release_e5", 32'(btn_release[4]), 32'h0);
            if (c == 6) checkOutput("d_release_e6", 32'(btn_release[4]), 32'h1);
            if (c == 7) checkOutput("d_release_e7", 32'(btn_release[4]), 32'h0);
        end
        checkOutput("d_no_press", 32'(seen), 32'h0);
        checkOutput("d_level_off", 32'(btn_level[4]), 32'h0);

        checkOutput("sb_drain", 32'(sbQ.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule
